// File: rtl/pattern_sequencer.sv
// pattern_sequencer: latches one turn's attack pattern and issues one spawn per slot.
// Optional `SKIP_EMPTY_SLOT_EN: a speed==0 slot is consumed without a spawn request.
module pattern_sequencer #(
  parameter int NUM_SLOTS = 24,
  parameter int NUM_TURNS = 10,
  parameter int TURN_W    = 4
) (
  input  logic                   clk_in,
  input  logic                   rst_n_in,
  input  logic                   start_in,
  input  logic                   pause_in,
  input  logic                   tick_in,
  input  logic                   pattern_valid_in,
  input  logic [3*NUM_SLOTS-1:0] timing_in,
  input  logic [3*NUM_SLOTS-1:0] speed_in,
  input  logic [2*NUM_SLOTS-1:0] direction_in,
  input  logic [NUM_SLOTS-1:0]   inversed_in,
  input  logic                   spawn_ready_in,
  output logic [TURN_W-1:0]      turn_out,
  output logic                   spawn_valid_out,
  output logic [4:0]             spawn_idx_out,
  output logic [2:0]             spawn_speed_out,
  output logic [1:0]             spawn_dir_out,
  output logic                   spawn_inv_out,
  output logic                   busy_out,
  output logic                   done_out,
  output logic                   error_out
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LOAD  = 3'd1;
  localparam logic [2:0] S_WAIT  = 3'd2;
  localparam logic [2:0] S_ISSUE = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  localparam logic [4:0] LAST_SLOT = 5'(NUM_SLOTS - 1);
  localparam logic [TURN_W-1:0] LAST_TURN = TURN_W'(NUM_TURNS - 1);

  typedef struct packed {
    logic [4:0] idx;
    logic [2:0] speed;
    logic [1:0] dir;
    logic       inv;
  } spawn_t;

  logic [2:0] st;
  logic [2:0] nxt;
  logic [4:0] slot;
  logic [2:0] cnt;

  logic [3*NUM_SLOTS-1:0] timing_q;
  logic [3*NUM_SLOTS-1:0] speed_q;
  logic [2*NUM_SLOTS-1:0] dir_q;
  logic [NUM_SLOTS-1:0]   inv_q;

  spawn_t     cur;
  spawn_t     spawn_q;
  logic [2:0] cur_time;
  logic       cur_empty;
  logic       load_ok;
  logic       load_miss;
  logic       cnt_step;
  logic       accept;
  logic       last;
  logic       go_valid;

  assign cur_time = timing_q[3*slot +: 3];

  always_comb begin
    cur       = '0;
    cur.idx   = slot;
    cur.speed = speed_q[3*slot +: 3];
    cur.dir   = dir_q[2*slot +: 2];
    cur.inv   = inv_q[slot];
  end

`ifdef SKIP_EMPTY_SLOT_EN
  assign cur_empty = (cur.speed == 3'd0);
`else
  assign cur_empty = 1'b0;
`endif

  assign load_ok   = (st == S_LOAD) && pattern_valid_in;
  assign load_miss = (st == S_LOAD) && !pattern_valid_in;
  assign last      = (slot == LAST_SLOT);

  // ticks only count while waiting and unpaused; elsewhere they are dropped
  assign cnt_step = (st == S_WAIT) && !pause_in
                 && tick_in && (cnt != cur_time);

  // an empty slot consumes itself without a handshake
  assign accept = (st == S_ISSUE)
               && (cur_empty || (spawn_valid_out && spawn_ready_in));

  always_comb begin
    nxt = st;
    unique case (st)
      S_IDLE:  if (start_in) nxt = S_LOAD;
      S_LOAD:  nxt = pattern_valid_in ? S_WAIT : S_IDLE;
      S_WAIT:  if (!pause_in && cnt == cur_time) nxt = S_ISSUE;
      S_ISSUE: if (accept) nxt = last ? S_DONE : S_WAIT;
      S_DONE:  nxt = S_IDLE;
      default: nxt = S_IDLE;
    endcase
  end

  assign go_valid = (nxt == S_ISSUE) && !cur_empty;

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      timing_q <= '0;
      speed_q  <= '0;
      dir_q    <= '0;
      inv_q    <= '0;
    end else if (load_ok) begin
      timing_q <= timing_in;
      speed_q  <= speed_in;
      dir_q    <= direction_in;
      inv_q    <= inversed_in;
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      st   <= S_IDLE;
      slot <= 5'd0;
      cnt  <= 3'd0;
    end else begin
      st <= nxt;
      if (load_ok) begin
        slot <= 5'd0;
        cnt  <= 3'd0;
      end else if (accept && !last) begin
        slot <= slot + 5'd1;
        cnt  <= 3'd0;
      end else if (cnt_step) begin
        cnt <= cnt + 3'd1;
      end
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      turn_out <= '0;
    end else if (st == S_DONE) begin
      if (turn_out == LAST_TURN) turn_out <= '0;
      else turn_out <= turn_out + TURN_W'(1);
    end
  end

  // payload is only loaded while valid will be high, so it holds until accept
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      spawn_valid_out <= 1'b0;
      spawn_q         <= '0;
      busy_out        <= 1'b0;
      done_out        <= 1'b0;
      error_out       <= 1'b0;
    end else begin
      spawn_valid_out <= go_valid;
      spawn_q         <= go_valid ? cur : '0;
      busy_out        <= (nxt != S_IDLE);
      done_out        <= (nxt == S_DONE);
      error_out       <= load_miss;
    end
  end

  assign spawn_idx_out   = spawn_q.idx;
  assign spawn_speed_out = spawn_q.speed;
  assign spawn_dir_out   = spawn_q.dir;
  assign spawn_inv_out   = spawn_q.inv;

endmodule

// File: tb/tb_pattern_sequencer.sv
// tb_pattern_sequencer: randomized bench checked against a behavioural pattern model.
// Define SKIP_EMPTY_SLOT_EN to build the bench and design with empty-slot skipping.
module tb_pattern_sequencer;

`ifdef SKIP_EMPTY_SLOT_EN
  localparam bit SKIP = 1'b1;
`else
  localparam bit SKIP = 1'b0;
`endif

  localparam int P_IDLE  = 0;
  localparam int P_LOAD  = 1;
  localparam int P_WAIT  = 2;
  localparam int P_ISSUE = 3;
  localparam int P_DONE  = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        pause = 1'b0;
  logic        tick = 1'b0;
  logic        pv = 1'b0;
  logic        ready = 1'b0;
  logic [71:0] timing = '0;
  logic [71:0] speed = '0;
  logic [47:0] dir = '0;
  logic [23:0] inv = '0;

  logic [3:0] turn;
  logic       sv;
  logic [4:0] sidx;
  logic [2:0] sspd;
  logic [1:0] sdir;
  logic       sinv;
  logic       busy;
  logic       done;
  logic       err;

  pattern_sequencer dut (
    .clk_in           (clk),
    .rst_n_in         (rst_n),
    .start_in         (start),
    .pause_in         (pause),
    .tick_in          (tick),
    .pattern_valid_in (pv),
    .timing_in        (timing),
    .speed_in         (speed),
    .direction_in     (dir),
    .inversed_in      (inv),
    .spawn_ready_in   (ready),
    .turn_out         (turn),
    .spawn_valid_out  (sv),
    .spawn_idx_out    (sidx),
    .spawn_speed_out  (sspd),
    .spawn_dir_out    (sdir),
    .spawn_inv_out    (sinv),
    .busy_out         (busy),
    .done_out         (done),
    .error_out        (err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d",
               name, act, exp);
    end
  endtask

  // model: phase of the turn, slot in hand, ticks still owed
  int ph;
  int m_slot;
  int m_need;
  int m_turn;
  bit m_valid;
  bit m_busy;
  bit m_done;
  bit m_err;
  logic [71:0] lt;
  logic [71:0] ls;
  logic [47:0] ld;
  logic [23:0] li;
  bit cmp_en = 1'b0;

  function automatic bit empty_slot(input int s);
    return SKIP && (ls[3*s +: 3] == 3'd0);
  endfunction

  task automatic model_reset();
    ph = P_IDLE;
    m_slot = 0;
    m_need = 0;
    m_turn = 0;
    m_valid = 1'b0;
    m_busy = 1'b0;
    m_done = 1'b0;
    m_err = 1'b0;
    lt = '0;
    ls = '0;
    ld = '0;
    li = '0;
  endtask

  task automatic model_step();
    bit acc;
    m_err = 1'b0;
    case (ph)
      P_IDLE: if (start) ph = P_LOAD;
      P_LOAD: begin
        if (pv) begin
          lt = timing;
          ls = speed;
          ld = dir;
          li = inv;
          m_slot = 0;
          m_need = int'(lt[2:0]);
          ph = P_WAIT;
        end else begin
          m_err = 1'b1;
          ph = P_IDLE;
        end
      end
      P_WAIT: begin
        if (!pause) begin
          if (m_need == 0) ph = P_ISSUE;
          else if (tick) m_need--;
        end
      end
      P_ISSUE: begin
        acc = empty_slot(m_slot) || (m_valid && ready);
        if (acc) begin
          if (m_slot == 23) begin
            ph = P_DONE;
          end else begin
            m_slot++;
            m_need = int'(lt[3*m_slot +: 3]);
            ph = P_WAIT;
          end
        end
      end
      P_DONE: begin
        m_turn = (m_turn + 1) % 10;
        ph = P_IDLE;
      end
      default: ph = P_IDLE;
    endcase
    m_valid = (ph == P_ISSUE) && !empty_slot(m_slot);
    m_busy = (ph != P_IDLE);
    m_done = (ph == P_DONE);
  endtask

  always @(negedge clk) begin
    if (cmp_en && rst_n) begin
      chk("turn", 32'(turn), 32'(m_turn));
      chk("busy", 32'(busy), 32'(m_busy));
      chk("done", 32'(done), 32'(m_done));
      chk("error", 32'(err), 32'(m_err));
      chk("valid", 32'(sv), 32'(m_valid));
      if (m_valid) begin
        chk("idx", 32'(sidx), 32'(m_slot));
        chk("speed", 32'(sspd), 32'(ls[3*m_slot +: 3]));
        chk("dir", 32'(sdir), 32'(ld[2*m_slot +: 2]));
        chk("inv", 32'(sinv), 32'(li[m_slot]));
      end
    end
  end

  task automatic cycle();
    @(posedge clk);
    if (rst_n) model_step();
    @(negedge clk);
  endtask

  task automatic rand_vecs(input bit fast);
    for (int i = 0; i < 24; i++) begin
      timing[3*i +: 3] = fast ? 3'd0 : 3'($urandom_range(0, 7));
      speed[3*i +: 3] = fast ? 3'($urandom_range(1, 7))
                             : 3'($urandom_range(0, 7));
      dir[2*i +: 2] = 2'($urandom_range(0, 3));
      inv[i] = 1'($urandom_range(0, 1));
    end
  endtask

  int acc_q[$];
  int ndone;

  task automatic start_pattern();
    start = 1'b1;
    cycle();
    start = 1'b0;
  endtask

  task automatic run_to_idle(input bit rnd);
    int k;
    k = 0;
    while (busy && k < 3000) begin
      if (rnd) begin
        tick = ($urandom_range(0, 2) == 0);
        pause = ($urandom_range(0, 7) == 0);
        ready = ($urandom_range(0, 3) != 0);
        start = ($urandom_range(0, 15) == 0);
      end else begin
        tick = 1'b0;
        pause = 1'b0;
        ready = 1'b1;
        start = 1'b0;
      end
      if (k > 0) rand_vecs(!rnd);
      if (sv && ready) acc_q.push_back(int'(sidx));
      if (done) ndone++;
      cycle();
      k++;
    end
    start = 1'b0;
    tick = 1'b0;
    pause = 1'b0;
    chk("idle_timeout", 32'(k < 3000), 32'd1);
  endtask

  initial begin
    int lat;
    int nt;
    int k;
    int bad;
    int nv;
    int exp_n;
    logic [2:0] sp0;
    logic [1:0] dr0;
    logic       iv0;

    model_reset();
    repeat (3) @(negedge clk);
    chk("rst_turn", 32'(turn), 32'd0);
    chk("rst_valid", 32'(sv), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_error", 32'(err), 32'd0);
    rst_n = 1'b1;
    cmp_en = 1'b1;
    cycle();

    // all timing zero, always ready
    rand_vecs(1'b1);
    pv = 1'b1;
    ready = 1'b1;
    start_pattern();
    lat = 1;
    while (!sv && lat < 20) begin
      cycle();
      lat++;
    end
    chk("first_valid_latency", 32'(lat), 32'd3);
    acc_q.delete();
    ndone = 0;
    run_to_idle(1'b0);
    chk("fast_accepts", 32'(acc_q.size()), 32'd24);
    bad = 0;
    foreach (acc_q[i]) if (acc_q[i] != i) bad++;
    chk("fast_idx_order", 32'(bad), 32'd0);
    chk("fast_done_pulses", 32'(ndone), 32'd1);
    chk("turn_after_first", 32'(turn), 32'd1);

    // slot0 waits 3 ticks, slot1 waits 2; a stalled issue drops ticks
    rand_vecs(1'b1);
    timing[2:0] = 3'd3;
    timing[5:3] = 3'd2;
    sp0 = speed[2:0];
    dr0 = dir[1:0];
    iv0 = inv[0];
    ready = 1'b0;
    start_pattern();
    cycle();
    nt = 0;
    k = 0;
    while (!sv && k < 60) begin
      tick = (k % 3 == 0);
      if (tick) nt++;
      cycle();
      k++;
    end
    tick = 1'b0;
    chk("slot0_ticks", 32'(nt), 32'd3);
    chk("slot0_idx", 32'(sidx), 32'd0);
    for (int i = 0; i < 5; i++) begin
      tick = 1'b1;
      rand_vecs(1'b0);
      cycle();
      chk("stall_valid", 32'(sv), 32'd1);
      chk("stall_payload", 32'({sidx, sspd, sdir, sinv}),
          32'({5'd0, sp0, dr0, iv0}));
    end
    tick = 1'b0;
    ready = 1'b1;
    cycle();
    nt = 0;
    k = 0;
    while (!sv && k < 60) begin
      tick = (k % 3 == 0);
      if (tick) nt++;
      cycle();
      k++;
    end
    tick = 1'b0;
    chk("slot1_ticks", 32'(nt), 32'd2);
    chk("slot1_idx", 32'(sidx), 32'd1);
    run_to_idle(1'b0);
    chk("turn_after_second", 32'(turn), 32'd2);

    // randomized turns: ticks, pause, backpressure, misses, stray starts
    for (int p = 0; p < 25; p++) begin
      rand_vecs(1'b0);
      pv = ($urandom_range(0, 9) != 0);
      repeat ($urandom_range(0, 3)) cycle();
      start_pattern();
      run_to_idle(1'b1);
    end
    pv = 1'b1;

    // turn wrap and bank miss
    for (int p = 0; p < 12 && m_turn != 9; p++) begin
      rand_vecs(1'b1);
      start_pattern();
      run_to_idle(1'b0);
    end
    chk("turn_at_nine", 32'(turn), 32'd9);
    pv = 1'b0;
    start_pattern();
    run_to_idle(1'b0);
    chk("miss_error_pulse", 32'(err), 32'd1);
    chk("miss_turn_kept", 32'(turn), 32'd9);
    pv = 1'b1;
    cycle();
    chk("miss_error_clears", 32'(err), 32'd0);
    rand_vecs(1'b1);
    start_pattern();
    run_to_idle(1'b0);
    chk("turn_wrapped", 32'(turn), 32'd0);

    // slot 4 has speed zero
    rand_vecs(1'b1);
    speed[14:12] = 3'd0;
    acc_q.delete();
    ndone = 0;
    start_pattern();
    run_to_idle(1'b0);
    exp_n = SKIP ? 23 : 24;
    chk("empty_accepts", 32'(acc_q.size()), 32'(exp_n));
    bad = 0;
    foreach (acc_q[i]) begin
      if (acc_q[i] != ((SKIP && i >= 4) ? i + 1 : i)) bad++;
    end
    chk("empty_idx_order", 32'(bad), 32'd0);
    chk("empty_done", 32'(ndone), 32'd1);

    // reset while waiting on slot 7
    rand_vecs(1'b1);
    timing[23:21] = 3'd7;
    start_pattern();
    k = 0;
    while (!(ph == P_WAIT && m_slot == 7) && k < 200) begin
      ready = 1'b1;
      cycle();
      k++;
    end
    chk("reach_slot7", 32'(k < 200), 32'd1);
    chk("slot7_busy", 32'(busy), 32'd1);
    cmp_en = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("arst_valid", 32'(sv), 32'd0);
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_turn", 32'(turn), 32'd0);
    chk("arst_idx", 32'(sidx), 32'd0);
    chk("arst_done_err", 32'({done, err}), 32'd0);
    model_reset();
    cycle();
    cycle();
    rst_n = 1'b1;
    cmp_en = 1'b1;
    nv = 0;
    for (int i = 0; i < 20; i++) begin
      tick = 1'b1;
      ready = ($urandom_range(0, 1) == 1);
      cycle();
      if (sv) nv++;
    end
    tick = 1'b0;
    chk("no_valid_after_reset", 32'(nv), 32'd0);
    chk("idle_after_reset", 32'(busy), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
